// File: rtl/cs_arb_pkg.sv
// Shared types and helpers for the round-robin chip-select arbiter.
package cs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } cs_state_e;

  localparam int NUM_CH = 8;

  // Active-low one-hot select; channel idx drives bit 7-idx.
  function automatic logic [7:0] onehot_n(input logic [2:0] idx);
    logic [7:0] y;
    y = 8'hFF;
    y[3'd7 - idx] = 1'b0;
    return y;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotate-priority picker: first requester after `last`, wrapping, with `last` searched last.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] last,
  output logic [2:0] pick,
  output logic       any
);

  always_comb begin
    pick = last;
    any  = |req;
    // Walk from the farthest offset to the nearest so the nearest requester wins.
    for (int i = 8; i >= 1; i--) begin
      if (req[last + 3'(i)]) begin
        pick = last + 3'(i);
      end
    end
  end

endmodule

// File: rtl/cs_rr_arbiter.sv
// Eight-way round-robin chip-select arbiter with bounded hold time and a break-before-make gap.
module cs_rr_arbiter
  import cs_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      En,
  input  logic [7:0] req,
  output logic [7:0] Y,
  output logic [2:0] gnt_idx,
  output logic      gnt_valid,
  output cs_state_e dbg_state
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  cs_state_e  state_q, state_d;
  logic [7:0] y_q, y_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gap_q, gap_d;

  logic [2:0] pick;
  logic       any;
  logic       owner_req;
  logic       others_req;

  rr_pick8 u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  assign owner_req  = req[owner_q];
  assign others_req = |(req & ~(8'b1 << owner_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= 8'hFF;
      owner_q <= 3'd0;
      last_q  <= 3'd7;
      hold_q  <= 8'd0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (En && any) state_d = GRANT;
      end
      GRANT: begin
        if (!En)                                          state_d = IDLE;
        else if (!owner_req)                              state_d = GAP;
        else if ((hold_q == HOLD_LAST) && others_req)     state_d = GAP;
      end
      GAP: begin
        if (!En)                     state_d = IDLE;
        else if (gap_q == GAP_LAST)  state_d = any ? GRANT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and counters follow the state being entered.
  always_comb begin
    y_d     = 8'hFF;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = 8'd0;
    gap_d   = 4'd0;
    if (state_d == GRANT && state_q != GRANT) begin
      owner_d = pick;
      last_d  = pick;
      y_d     = onehot_n(pick);
    end else if (state_d == GRANT) begin
      y_d    = onehot_n(owner_q);
      hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 8'd1;
    end else if (state_d == GAP && state_q == GAP) begin
      gap_d = gap_q + 4'd1;
    end
  end

  assign Y         = y_q;
  assign gnt_idx   = owner_q;
  assign gnt_valid = ~&y_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cs_rr_arbiter.sv
// Randomized and directed bench for cs_rr_arbiter against a cycle-level reference model.
module tb_cs_rr_arbiter;
  import cs_arb_pkg::*;

  localparam int MAX_HOLD   = 4;
  localparam int GAP_CYCLES = 1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] y;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  cs_state_e  dbg_state;

  always #5 clk = ~clk;

  cs_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .En        (en),
    .req       (req),
    .Y         (y),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];
  bit   sb_on = 1'b0;
  logic prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner = -1 means no select; gap_left counts remaining dead cycles.
  int m_owner, m_last, m_held, m_gap_left, m_idx;

  function automatic int model_pick(input logic [7:0] r, input int last);
    for (int off = 1; off <= 8; off++) begin
      if (r[(last + off) % 8]) return (last + off) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 7; m_held = 0; m_gap_left = 0; m_idx = 0;
  endtask

  task automatic model_grant(input logic [7:0] r);
    m_owner = model_pick(r, m_last);
    m_last  = m_owner;
    m_idx   = m_owner;
    m_held  = 0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] r);
    logic [7:0] others;
    if (!e) begin
      m_owner = -1; m_gap_left = 0; m_held = 0;
    end else if (m_owner >= 0) begin
      m_held++;
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner] || (m_held >= MAX_HOLD && others != 8'h00)) begin
        m_owner = -1;
        m_gap_left = GAP_CYCLES;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
      if (m_gap_left == 0 && r != 8'h00) model_grant(r);
    end else if (r != 8'h00) begin
      model_grant(r);
    end
  endtask

  function automatic logic [7:0] model_y();
    logic [7:0] v;
    v = 8'hFF;
    if (m_owner >= 0) v[7 - m_owner] = 1'b0;
    return v;
  endfunction

  function automatic cs_state_e model_state();
    if (m_owner >= 0)   return GRANT;
    if (m_gap_left > 0) return GAP;
    return IDLE;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_y"},     32'(y),         32'(model_y()));
    chk({tag, "_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    chk({tag, "_idx"},   32'(gnt_idx),   32'(m_idx));
    chk({tag, "_state"}, 32'(dbg_state), 32'(model_state()));
    if (sb_on && gnt_valid && !prev_valid) begin
      if (exp_q.size() > 0) chk("rr_order", 32'(gnt_idx), 32'(exp_q.pop_front()));
      else chk("rr_extra_grant", 32'(gnt_idx), 32'hFFFF_FFFF);
    end
    prev_valid = gnt_valid;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic e, input logic [7:0] r, input string tag);
    en  = e;
    req = r;
    @(posedge clk);
    model_step(e, r);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    en = 1'b0; req = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_y", 32'(y), 32'hFF);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; en = 1'b0; req = 8'h00;
    model_reset();
    #2;
    do_reset();
    cycle(1'b1, 8'h00, "idle");

    // Single requester: channel 2, then release and gap.
    cycle(1'b1, 8'h04, "ch2");
    chk("ch2_y_const", 32'(y), 32'hDF);
    chk("ch2_idx_const", 32'(gnt_idx), 32'd2);
    cycle(1'b1, 8'h04, "ch2_hold");
    cycle(1'b1, 8'h00, "ch2_rel");
    chk("ch2_gap_y", 32'(y), 32'hFF);
    cycle(1'b1, 8'h00, "ch2_idle");
    chk("ch2_idle_state", 32'(dbg_state), 32'(IDLE));

    // All requesting: strict rotation with MAX_HOLD-cycle grants.
    do_reset();
    for (int k = 0; k < 8; k++) exp_q.push_back(3'(k));
    exp_q.push_back(3'd0);
    sb_on = 1'b1;
    for (int i = 0; i < 43; i++) cycle(1'b1, 8'hFF, "rr");
    sb_on = 1'b0;
    chk("rr_all_seen", 32'(exp_q.size()), 32'd0);

    // Pointer wrap: owner 7, then channels 0 and 6.
    for (int i = 0; i < 12 && m_owner != 7; i++) cycle(1'b1, 8'h80, "wrap_wait");
    chk("wrap_own7", 32'(gnt_idx), 32'd7);
    cycle(1'b1, 8'h41, "wrap_rel");
    cycle(1'b1, 8'h41, "wrap_pick");
    chk("wrap_y_const", 32'(y), 32'h7F);

    // Lone requester keeps the bus indefinitely, then async reset mid-grant.
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 8'h08, "ch3");
      if (i >= 3) chk("ch3_cont", 32'(y), 32'hEF);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_y", 32'(y), 32'hFF);
    chk("async_rst_valid", 32'(gnt_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_valid = 1'b0;

    // Enable dropped mid-grant of channel 5; pointer survives.
    cycle(1'b1, 8'h20, "ch5");
    cycle(1'b1, 8'h20, "ch5_hold");
    cycle(1'b0, 8'h20, "en_off");
    chk("en_off_y", 32'(y), 32'hFF);
    cycle(1'b0, 8'h60, "en_off2");
    cycle(1'b1, 8'h60, "en_on");
    chk("en_on_idx", 32'(gnt_idx), 32'd6);

    // Randomized traffic with occasional enable drops.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      logic       e;
      e = ($urandom_range(0, 19) != 0);
      case ($urandom_range(0, 3))
        0: r = 8'h00;
        1: r = 8'(1 << $urandom_range(0, 7));
        default: r = 8'($urandom_range(0, 255));
      endcase
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) cycle(e, r, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
